// File: rtl/markov_transition_learner.sv
// Counts symbol-pair transitions of a captured fragment into an insertion-ordered list (MARKOV_COUNT_SAT_EN: saturating counts).
// start-to-done latency 2*FRAG_LEN-1 cycles; start/clear are ignored while busy, no other flow control.
module markov_transition_learner #(
  parameter int SYM_W      = 8,
  parameter int FRAG_LEN   = 150,
  parameter int LIST_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            clear,
  input  logic [FRAG_LEN*SYM_W-1:0]       frag,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [$clog2(LIST_DEPTH+1)-1:0] entries,
  input  logic [$clog2(LIST_DEPTH)-1:0]   rd_idx,
  output logic [SYM_W-1:0]                rd_from,
  output logic [SYM_W-1:0]                rd_to,
  output logic [CNT_W-1:0]                rd_count
);

  localparam int E_W   = $clog2(LIST_DEPTH+1);
  localparam int IDX_W = $clog2(LIST_DEPTH);
  localparam int P_W   = $clog2(FRAG_LEN);
  localparam logic [P_W-1:0] P_LAST = P_W'(FRAG_LEN-2);
  localparam logic [E_W-1:0] E_FULL = E_W'(LIST_DEPTH);

  typedef struct packed {
    logic [SYM_W-1:0] src;
    logic [SYM_W-1:0] dst;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE, FINISH} state_t;

  state_t                    state_q, state_d;
  logic [FRAG_LEN*SYM_W-1:0] frag_q;
  logic [SYM_W-1:0]          sym [FRAG_LEN];
  logic [P_W-1:0]            p_q, p_nxt;
  entry_t                    lst [LIST_DEPTH];
  logic                      hit_q, hit_d;
  logic [IDX_W-1:0]          hit_idx_q, hit_idx_d;
  logic [SYM_W-1:0]          pair_from, pair_to;
  logic                      go, wipe, full;

  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
`ifdef MARKOV_COUNT_SAT_EN
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  for (genvar g = 0; g < FRAG_LEN; g++) begin : g_sym
    assign sym[g] = frag_q[g*SYM_W +: SYM_W];
  end

  assign p_nxt     = p_q + 1'b1;
  assign pair_from = sym[p_q];
  assign pair_to   = sym[p_nxt];
  assign busy      = (state_q != IDLE);
  // clear takes priority over start when both arrive in IDLE
  assign wipe      = (state_q == IDLE) && clear;
  assign go        = (state_q == IDLE) && start && !clear;
  assign full      = (entries == E_FULL);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = CHECK;
      CHECK:   state_d = UPDATE;
      UPDATE:  state_d = (p_q < P_LAST) ? CHECK : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    for (int i = 0; i < LIST_DEPTH; i++) begin
      if ((E_W'(i) < entries) && lst[i].src == pair_from && lst[i].dst == pair_to) begin
        hit_d     = 1'b1;
        hit_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entries   <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      p_q       <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      done <= (state_q == FINISH);
      if (wipe) begin
        entries  <= '0;
        overflow <= 1'b0;
      end
      if (go) p_q <= '0;
      if (state_q == CHECK) begin
        hit_q     <= hit_d;
        hit_idx_q <= hit_idx_d;
      end
      if (state_q == UPDATE) begin
        if (p_q < P_LAST) p_q <= p_nxt;
        if (!hit_q) begin
          if (!full) entries  <= entries + 1'b1;
          else       overflow <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: entries masks everything beyond the valid region.
  always_ff @(posedge clk) begin
    if (go) frag_q <= frag;
    if (reset && state_q == UPDATE) begin
      if (hit_q)
        lst[hit_idx_q].cnt <= count_inc(lst[hit_idx_q].cnt);
      else if (!full)
        lst[entries[IDX_W-1:0]] <= '{src: pair_from, dst: pair_to, cnt: CNT_W'(1)};
    end
  end

  always_comb begin
    rd_from  = '0;
    rd_to    = '0;
    rd_count = '0;
    if (E_W'(rd_idx) < entries) begin
      rd_from  = lst[rd_idx].src;
      rd_to    = lst[rd_idx].dst;
      rd_count = lst[rd_idx].cnt;
    end
  end

endmodule

// File: tb/tb_markov_transition_learner.sv
// Bench for markov_transition_learner: two instances (list depth 4 and 2) share stimulus and are
// checked against a list-of-pairs reference model.
module tb_markov_transition_learner;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic [15:0] frag;
  logic [1:0]  rd_idx;

  logic       busy_a, done_a, ovf_a;
  logic [2:0] ent_a;
  logic [3:0] from_a, to_a, cnt_a;
  logic       busy_b, done_b, ovf_b;
  logic [1:0] ent_b;
  logic [3:0] from_b, to_b, cnt_b;

  int checks = 0;
  int failures = 0;

  int m_n   [2];
  int m_ovf [2];
  int m_src [2][4];
  int m_dst [2][4];
  int m_cnt [2][4];

  always #5 clk = ~clk;

  markov_transition_learner #(.SYM_W(4), .FRAG_LEN(4), .LIST_DEPTH(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .frag(frag),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .entries(ent_a),
    .rd_idx(rd_idx), .rd_from(from_a), .rd_to(to_a), .rd_count(cnt_a));

  markov_transition_learner #(.SYM_W(4), .FRAG_LEN(4), .LIST_DEPTH(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .frag(frag),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .entries(ent_b),
    .rd_idx(rd_idx[0]), .rd_from(from_b), .rd_to(to_b), .rd_count(cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int next_count(input int c);
`ifdef MARKOV_COUNT_SAT_EN
    return (c >= 15) ? 15 : c + 1;
`else
    return (c + 1) % 16;
`endif
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_n[d]   = 0;
      m_ovf[d] = 0;
    end
  endtask

  task automatic model_run(input logic [15:0] f);
    int a, b, hit;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 3; p++) begin
        a = int'(f[p*4 +: 4]);
        b = int'(f[(p+1)*4 +: 4]);
        hit = -1;
        for (int i = 0; i < m_n[d]; i++)
          if (m_src[d][i] == a && m_dst[d][i] == b) hit = i;
        if (hit >= 0) begin
          m_cnt[d][hit] = next_count(m_cnt[d][hit]);
        end else if (m_n[d] < depth_of(d)) begin
          m_src[d][m_n[d]] = a;
          m_dst[d][m_n[d]] = b;
          m_cnt[d][m_n[d]] = 1;
          m_n[d]++;
        end else begin
          m_ovf[d] = 1;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    int es, ed, ec;
    chk($sformatf("%s.entries_a", tag), 32'(ent_a), m_n[0]);
    chk($sformatf("%s.overflow_a", tag), 32'(ovf_a), m_ovf[0]);
    chk($sformatf("%s.entries_b", tag), 32'(ent_b), m_n[1]);
    chk($sformatf("%s.overflow_b", tag), 32'(ovf_b), m_ovf[1]);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      es = (i < m_n[0]) ? m_src[0][i] : 0;
      ed = (i < m_n[0]) ? m_dst[0][i] : 0;
      ec = (i < m_n[0]) ? m_cnt[0][i] : 0;
      chk($sformatf("%s.a[%0d].from", tag, i), 32'(from_a), es);
      chk($sformatf("%s.a[%0d].to", tag, i), 32'(to_a), ed);
      chk($sformatf("%s.a[%0d].count", tag, i), 32'(cnt_a), ec);
      if (i < 2) begin
        es = (i < m_n[1]) ? m_src[1][i] : 0;
        ed = (i < m_n[1]) ? m_dst[1][i] : 0;
        ec = (i < m_n[1]) ? m_cnt[1][i] : 0;
        chk($sformatf("%s.b[%0d].from", tag, i), 32'(from_b), es);
        chk($sformatf("%s.b[%0d].to", tag, i), 32'(to_b), ed);
        chk($sformatf("%s.b[%0d].count", tag, i), 32'(cnt_b), ec);
      end
    end
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check_state(tag);
  endtask

  // poke: fire start+clear while the run is busy; both must be ignored
  task automatic run_frag(input string tag, input logic [15:0] f, input bit poke);
    int lat_a, lat_b;
    @(negedge clk);
    frag  = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frag  = ~f;
    chk($sformatf("%s.busy", tag), 32'(busy_a && busy_b), 1);
    lat_a = -1;
    lat_b = -1;
    for (int n = 0; n < 20 && lat_a < 0; n++) begin
      if (done_a) lat_a = n;
      if (done_b) lat_b = n;
      if (lat_a < 0) begin
        start = poke && (n == 2);
        clear = poke && (n == 2);
        @(negedge clk);
      end
    end
    start = 1'b0;
    clear = 1'b0;
    chk($sformatf("%s.done_latency_a", tag), 32'(lat_a), 7);
    chk($sformatf("%s.done_latency_b", tag), 32'(lat_b), 7);
    chk($sformatf("%s.busy_at_done", tag), 32'(busy_a), 0);
    @(negedge clk);
    chk($sformatf("%s.done_one_cycle", tag), 32'(done_a || done_b), 0);
    model_run(f);
    check_state(tag);
  endtask

  initial begin
    int dones;
    logic [15:0] rf;

    reset  = 1'b0;
    start  = 1'b0;
    clear  = 1'b0;
    frag   = '0;
    rd_idx = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy_a || busy_b), 0);
    chk("reset.done", 32'(done_a || done_b), 0);
    check_state("reset");
    reset = 1'b1;

    // basic run then accumulation on {1,2,1,2}
    do_clear("clear0");
    run_frag("basic", 16'h2121, 1'b0);
    chk("basic.idx0_count", 32'(m_cnt[0][0]), 2);
    run_frag("accum", 16'h2121, 1'b1);
    chk("accum.idx0_count", 32'(m_cnt[0][0]), 4);

    // overflow on the depth-2 instance with {0,1,2,3}, then clear
    do_clear("clear1");
    run_frag("ovf", 16'h3210, 1'b0);
    chk("ovf.flag_b", 32'(ovf_b), 1);
    do_clear("ovf_clear");

    // count limit: 18 increments on 5->5
    for (int r = 0; r < 6; r++) run_frag($sformatf("limit%0d", r), 16'h5555, 1'b0);
`ifdef MARKOV_COUNT_SAT_EN
    chk("limit.model_count", 32'(m_cnt[0][0]), 15);
`else
    chk("limit.model_count", 32'(m_cnt[0][0]), 2);
`endif

    // reset in the third cycle of a run: no done, list emptied
    @(negedge clk);
    frag  = 16'h4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done_a || done_b) dones++;
    end
    chk("abort.no_done", 32'(dones), 0);
    check_state("abort");

    // start and clear together in IDLE: clear wins
    run_frag("prio_fill", 16'h1234, 1'b0);
    @(negedge clk);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    chk("prio.busy", 32'(busy_a || busy_b), 0);
    model_clear();
    check_state("prio");

    // randomized runs over a small alphabet so repeats, self-loops and overflow all occur
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 4) == 0) do_clear($sformatf("rclr%0d", r));
      for (int j = 0; j < 4; j++) rf[j*4 +: 4] = 4'($urandom_range(0, 3));
      run_frag($sformatf("rand%0d", r), rf, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
